// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the RV32I multicycle main controller.
// Covers the state enum, opcodes, datapath select codes and trap causes.
package ctrl_pkg;

    localparam int unsigned OP_W      = 7;
    localparam int unsigned STATE_W   = 4;
    localparam int unsigned IMM_SRC_W = 3;
    localparam int unsigned CAUSE_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_LINK,
        S_AUIPC,
        S_LUI,
        S_TRAP
    } state_e;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OP_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMM       = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [IMM_SRC_W-1:0] IMM_I = 3'b000;
    localparam logic [IMM_SRC_W-1:0] IMM_S = 3'b001;
    localparam logic [IMM_SRC_W-1:0] IMM_B = 3'b010;
    localparam logic [IMM_SRC_W-1:0] IMM_J = 3'b011;
    localparam logic [IMM_SRC_W-1:0] IMM_U = 3'b100;

    localparam logic [CAUSE_W-1:0] CAUSE_NONE    = 2'b00;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [CAUSE_W-1:0] CAUSE_TIMEOUT = 2'b10;

    // Per-cycle control word produced by the state decode.
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       trap;
    } ctrl_t;

    // States that hold a memory request open and are subject to the bus timeout.
    function automatic logic waits_on_mem(input state_e s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller-to-datapath/memory signal bundle for the multicycle core.
// master = controller side, slave = datapath/memory side.
interface multicycle_ctrl_if;

    logic [ctrl_pkg::OP_W-1:0]      op;
    logic                           mem_ready;
    logic                           mem_req;
    logic                           MemWrite;
    logic                           AdrSrc;
    logic                           IRWrite;
    logic                           PCUpdate;
    logic                           Branch;
    logic                           RegWrite;
    logic [1:0]                     ResultSrc;
    logic [1:0]                     ALUSrcA;
    logic [1:0]                     ALUSrcB;
    logic [1:0]                     ALUOp;
    logic [ctrl_pkg::IMM_SRC_W-1:0] ImmSrc;
    logic                           instr_done;
    logic                           trap;
    logic [ctrl_pkg::CAUSE_W-1:0]   trap_cause;

    modport master (
        input  op, mem_ready,
        output mem_req, MemWrite, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, trap, trap_cause
    );

    modport slave (
        output op, mem_ready,
        input  mem_req, MemWrite, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, trap, trap_cause
    );

endinterface

// File: rtl/immdec.sv
// Opcode to immediate-format decoder; purely combinational.
module immdec
    import ctrl_pkg::*;
(
    input  logic [OP_W-1:0]      i_op,
    output logic [IMM_SRC_W-1:0] o_imm_src_c
);

    // Loads, OP-IMM, jalr and unknown opcodes all fall back to the I format.
    always_comb begin
        o_imm_src_c = IMM_I;
        case (i_op)
            OP_STORE:         o_imm_src_c = IMM_S;
            OP_BRANCH:        o_imm_src_c = IMM_B;
            OP_JAL:           o_imm_src_c = IMM_J;
            OP_LUI, OP_AUIPC: o_imm_src_c = IMM_U;
            default:          o_imm_src_c = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the RV32I multicycle core: instruction sequencing,
// datapath selects, memory handshake, bus timeout and illegal-opcode trap.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT         = 16,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input logic               clk,
    input logic               reset_n,
    multicycle_ctrl_if.master bus
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e               r_state;
    state_e               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic [CAUSE_W-1:0]   r_trap_cause;
    logic [CAUSE_W-1:0]   w_cause_nxt;
    logic                 w_wait;
    logic                 w_timeout;
    logic [IMM_SRC_W-1:0] w_imm_src;
    ctrl_t                w_ctrl;
    ctrl_t                w_out;

    immdec u_immdec (
        .i_op        (bus.op),
        .o_imm_src_c (w_imm_src)
    );

    // Timeout fires on the TIMEOUT-th consecutive wait cycle; mem_ready that cycle wins.
    assign w_wait    = waits_on_mem(r_state) && !bus.mem_ready;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_timeout = (TIMEOUT != 0) && w_wait && (w_cnt_inc == CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_wait && (w_state_nxt == r_state)) begin
            r_cnt <= w_cnt_inc;
        end else begin
            r_cnt <= '0;
        end
    end

    // Cause is latched only on entry; TRAP is absorbing so the first cause sticks.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_trap_cause <= CAUSE_NONE;
        end else if ((r_state != S_TRAP) && (w_state_nxt == S_TRAP)) begin
            r_trap_cause <= w_cause_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = CAUSE_NONE;
        w_ctrl      = '0;

        case (r_state)
            S_FETCH: begin
                w_ctrl.mem_req    = 1'b1;
                w_ctrl.adr_src    = 1'b0;
                w_ctrl.alu_src_a  = SRCA_PC;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_ctrl.alu_op     = ALUOP_ADD;
                w_ctrl.result_src = RES_ALURESULT;
                if (bus.mem_ready) begin
                    w_ctrl.ir_write  = 1'b1;
                    w_ctrl.pc_update = 1'b1;
                    w_state_nxt      = S_DECODE;
                end else if (w_timeout) begin
                    w_state_nxt = S_TRAP;
                    w_cause_nxt = CAUSE_TIMEOUT;
                end
            end

            // Precompute the branch/jal target into ALUOut while decoding.
            S_DECODE: begin
                w_ctrl.alu_src_a = SRCA_OLDPC;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALUOP_ADD;
                case (bus.op)
                    OP_LOAD, OP_STORE: w_state_nxt = S_MEMADR;
                    OP_R:              w_state_nxt = S_EXECR;
                    OP_IMM:            w_state_nxt = S_EXECI;
                    OP_BRANCH:         w_state_nxt = S_BRANCH;
                    OP_JAL:            w_state_nxt = S_JAL;
                    OP_JALR:           w_state_nxt = S_JALR;
                    OP_AUIPC:          w_state_nxt = S_AUIPC;
                    OP_LUI:            w_state_nxt = S_LUI;
                    default: begin
                        if (TRAP_ON_ILLEGAL) begin
                            w_state_nxt = S_TRAP;
                            w_cause_nxt = CAUSE_ILLEGAL;
                        end else begin
                            w_ctrl.instr_done = 1'b1;
                            w_state_nxt       = S_FETCH;
                        end
                    end
                endcase
            end

            S_MEMADR: begin
                w_ctrl.alu_src_a = SRCA_RD1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_state_nxt      = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end

            S_MEMREAD: begin
                w_ctrl.mem_req    = 1'b1;
                w_ctrl.adr_src    = 1'b1;
                w_ctrl.result_src = RES_ALUOUT;
                if (bus.mem_ready) begin
                    w_state_nxt = S_MEMWB;
                end else if (w_timeout) begin
                    w_state_nxt = S_TRAP;
                    w_cause_nxt = CAUSE_TIMEOUT;
                end
            end

            S_MEMWB: begin
                w_ctrl.result_src = RES_DATA;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.instr_done = 1'b1;
                w_state_nxt       = S_FETCH;
            end

            S_MEMWRITE: begin
                w_ctrl.mem_req    = 1'b1;
                w_ctrl.mem_write  = 1'b1;
                w_ctrl.adr_src    = 1'b1;
                w_ctrl.result_src = RES_ALUOUT;
                if (bus.mem_ready) begin
                    w_ctrl.instr_done = 1'b1;
                    w_state_nxt       = S_FETCH;
                end else if (w_timeout) begin
                    w_state_nxt = S_TRAP;
                    w_cause_nxt = CAUSE_TIMEOUT;
                end
            end

            S_EXECR: begin
                w_ctrl.alu_src_a = SRCA_RD1;
                w_ctrl.alu_src_b = SRCB_RD2;
                w_ctrl.alu_op    = ALUOP_FUNCT;
                w_state_nxt      = S_ALUWB;
            end

            S_EXECI: begin
                w_ctrl.alu_src_a = SRCA_RD1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALUOP_FUNCT;
                w_state_nxt      = S_ALUWB;
            end

            S_ALUWB: begin
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.instr_done = 1'b1;
                w_state_nxt       = S_FETCH;
            end

            S_BRANCH: begin
                w_ctrl.alu_src_a  = SRCA_RD1;
                w_ctrl.alu_src_b  = SRCB_RD2;
                w_ctrl.alu_op     = ALUOP_BRANCH;
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.branch     = 1'b1;
                w_ctrl.instr_done = 1'b1;
                w_state_nxt       = S_FETCH;
            end

            // Jump target already sits in ALUOut; ALU forms the link address meanwhile.
            S_JAL: begin
                w_ctrl.alu_src_a  = SRCA_OLDPC;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.pc_update  = 1'b1;
                w_state_nxt       = S_ALUWB;
            end

            S_JALR: begin
                w_ctrl.alu_src_a  = SRCA_RD1;
                w_ctrl.alu_src_b  = SRCB_IMM;
                w_ctrl.result_src = RES_ALURESULT;
                w_ctrl.pc_update  = 1'b1;
                w_state_nxt       = S_LINK;
            end

            S_LINK: begin
                w_ctrl.alu_src_a = SRCA_OLDPC;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_state_nxt      = S_ALUWB;
            end

            S_AUIPC: begin
                w_ctrl.alu_src_a = SRCA_OLDPC;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_state_nxt      = S_ALUWB;
            end

            S_LUI: begin
                w_ctrl.result_src = RES_IMM;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.instr_done = 1'b1;
                w_state_nxt       = S_FETCH;
            end

            S_TRAP: begin
                w_ctrl.trap = 1'b1;
            end

            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // Everything is forced low while reset_n is asserted, even mid-access.
    assign w_out = reset_n ? w_ctrl : '0;

    assign bus.mem_req    = w_out.mem_req;
    assign bus.MemWrite   = w_out.mem_write;
    assign bus.AdrSrc     = w_out.adr_src;
    assign bus.IRWrite    = w_out.ir_write;
    assign bus.PCUpdate   = w_out.pc_update;
    assign bus.Branch     = w_out.branch;
    assign bus.RegWrite   = w_out.reg_write;
    assign bus.ResultSrc  = w_out.result_src;
    assign bus.ALUSrcA    = w_out.alu_src_a;
    assign bus.ALUSrcB    = w_out.alu_src_b;
    assign bus.ALUOp      = w_out.alu_op;
    assign bus.instr_done = w_out.instr_done;
    assign bus.trap       = w_out.trap;
    assign bus.ImmSrc     = reset_n ? w_imm_src : '0;
    assign bus.trap_cause = reset_n ? r_trap_cause : CAUSE_NONE;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the RV32I multicycle core, replacing the single-cycle combinational main decoder. Sequences each instruction through fetch/decode/execute/memory/writeback states, drives the shared-ALU datapath selects, and holds at memory states under a ready/valid handshake. Adds a bus-timeout counter and an illegal-opcode trap. Sits beside the ALU decoder; the datapath forms PCWrite = PCUpdate | (Branch & taken).

## Interface
Parameters:
- TIMEOUT, 16: max cycles waiting on mem_ready before trapping; 0 disables the timeout.
- TRAP_ON_ILLEGAL, 1: 1 = unknown opcode enters TRAP; 0 = treated as NOP.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- op  in  7  opcode of the instruction register
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request
- MemWrite  out  1  write strobe, valid with mem_req
- AdrSrc  out  1  0 = PC, 1 = Result as address
- IRWrite  out  1  load instruction register and OldPC
- PCUpdate  out  1  unconditional PC write
- Branch  out  1  conditional PC write
- RegWrite  out  1  register file write
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1
- ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
- ALUOp  out  2  00 add, 01 branch compare, 10 funct-decoded
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U (combinational from op)
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction
- trap  out  1  sticky fault flag
- trap_cause  out  2  00 none, 01 illegal opcode, 10 bus timeout

## Operation
Outputs not listed for a state are 0; ImmSrc depends only on op (unknown op: 000).
- FETCH: mem_req, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCUpdate only in the cycle mem_ready=1, then DECODE; otherwise hold.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jal target to ALUOut). Next: lw/sw→MEMADR, R→EXECR, I-ALU→EXECI, B→BRANCH, jal→JAL, jalr→JALR, auipc→AUIPC, lui→LUI, other→TRAP (or FETCH with instr_done if TRAP_ON_ILLEGAL=0).
- MEMADR: ALUSrcA=10, ALUSrcB=01; →MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: mem_req, AdrSrc=1, ResultSrc=00; on mem_ready →MEMWB.
- MEMWB: ResultSrc=01, RegWrite, instr_done; →FETCH.
- MEMWRITE: mem_req, MemWrite, AdrSrc=1, ResultSrc=00; on mem_ready, instr_done, →FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10; →ALUWB. EXECI: same with ALUSrcB=01.
- ALUWB: ResultSrc=00, RegWrite, instr_done; →FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch, instr_done; →FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCUpdate; →ALUWB.
- JALR: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, PCUpdate; →LINK. LINK: ALUSrcA=01, ALUSrcB=10; →ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01; →ALUWB. LUI: ResultSrc=11, RegWrite, instr_done; →FETCH.
- TRAP: all control outputs 0, trap=1; held until reset.
- Timeout: counter, width $clog2(TIMEOUT+1), increments each cycle in FETCH/MEMREAD/MEMWRITE with mem_ready=0, clears on mem_ready or state exit. Reaching TIMEOUT with mem_ready still 0 →TRAP, cause 10. mem_ready in the same cycle as the limit wins (no trap).

## Timing
- reset_n low at clk edge: state FETCH, counter 0, trap 0, trap_cause 00; all outputs held 0 while reset_n low, including mid-access. First FETCH cycle follows reset release.
- Latency with zero wait: lw 5, sw 4, R/I/auipc 4, jal 4, jalr 5, branch 3, lui 3 cycles; each wait cycle adds one.
- mem_req stays high until mem_ready; MemWrite never toggles within one request.
- trap_cause written on TRAP entry; first cause wins.

## Structure
- Package ctrl_pkg: state enum, opcode constants, ResultSrc/ALUSrcA/ALUSrcB/ALUOp/ImmSrc encodings, trap cause codes.
- Sub-module immdec: op→ImmSrc combinational decoder; FSM, counter, and output decode in multicycle_ctrl.

## Test plan
- lw (op 0000011), mem_ready=1 always → states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite and instr_done in cycle 5 only.
- sw with mem_ready low 3 cycles in MEMWRITE → mem_req/MemWrite high 4 cycles, one instr_done, no trap.
- FETCH with mem_ready held 0, TIMEOUT=16 → trap=1, cause 10 after 16 wait cycles; mem_ready at cycle 16 → no trap.
- op 1111111, TRAP_ON_ILLEGAL=1 → TRAP after DECODE, cause 01, sticky; =0 → instr_done, back to FETCH.
- jalr → PCUpdate with ResultSrc=10 in cycle 3, LINK, RegWrite in cycle 5; lui → ResultSrc=11, ImmSrc=100.
- reset_n low during MEMREAD wait → next cycle all outputs 0; after release, FETCH with mem_req=1, counter restarted.
